// File: rtl/key_event.sv
// Push-button front end: synchronises and debounces a raw key pin, then emits clean
// single-cycle press, release, short, long and auto-repeat events plus a debounced level.
module key_event #(
   parameter bit          ACTIVE_LOW   = 1'b1,
   parameter int unsigned DEBOUNCE_CYC = 1000000,
   parameter int unsigned LONG_CYC     = 50000000,
   parameter int unsigned REPEAT_CYC   = 10000000,
   parameter int unsigned CW           = 28
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam logic [CW-1:0] DebLast  = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] LongLast = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] RepLast  = CW'(REPEAT_CYC - 1);
   localparam logic [CW-1:0] One      = CW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StPressDb,
      StHeld,
      StLongHeld,
      StReleaseDb
   } state_e;

   state_e        state_q;
   logic [1:0]    sync_q;
   logic [CW-1:0] dcnt_q;
   logic [CW-1:0] hcnt_q;
   logic [CW-1:0] rcnt_q;
   logic          was_long_q;
   logic          level_q;
   logic          press_q;
   logic          release_q;
   logic          short_q;
   logic          long_q;
   logic          repeat_q;
   logic          key_s;

   // Normalised synchronised key: 1 = pressed regardless of pin polarity.
   assign key_s = sync_q[1] ^ ACTIVE_LOW;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q     <= {2{ACTIVE_LOW}};
         state_q    <= StIdle;
         dcnt_q     <= '0;
         hcnt_q     <= '0;
         rcnt_q     <= '0;
         was_long_q <= 1'b0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_in};
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (key_s) begin
                  state_q <= StPressDb;
                  dcnt_q  <= '0;
               end
            end

            StPressDb: begin
               if (!key_s) begin
                  state_q <= StIdle;
               end else if (dcnt_q == DebLast) begin
                  state_q    <= StHeld;
                  press_q    <= 1'b1;
                  level_q    <= 1'b1;
                  hcnt_q     <= '0;
                  was_long_q <= 1'b0;
               end else begin
                  dcnt_q <= dcnt_q + One;
               end
            end

            StHeld: begin
               if (!key_s) begin
                  state_q <= StReleaseDb;
                  dcnt_q  <= '0;
               end else if (hcnt_q == LongLast) begin
                  state_q    <= StLongHeld;
                  long_q     <= 1'b1;
                  was_long_q <= 1'b1;
                  rcnt_q     <= '0;
               end else begin
                  hcnt_q <= hcnt_q + One;
               end
            end

            StLongHeld: begin
               if (!key_s) begin
                  state_q <= StReleaseDb;
                  dcnt_q  <= '0;
               end else if (rcnt_q == RepLast) begin
                  repeat_q <= 1'b1;
                  rcnt_q   <= '0;
               end else begin
                  rcnt_q <= rcnt_q + One;
               end
            end

            StReleaseDb: begin
               // hcnt/rcnt stay frozen so a release glitch resumes where it left off.
               if (key_s) begin
                  state_q <= was_long_q ? StLongHeld : StHeld;
               end else if (dcnt_q == DebLast) begin
                  state_q   <= StIdle;
                  release_q <= 1'b1;
                  short_q   <= ~was_long_q;
                  level_q   <= 1'b0;
               end else begin
                  dcnt_q <= dcnt_q + One;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign key_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_pulse   = short_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: an active-low and an active-high instance are driven with the
// same logical key so every vector also covers pin polarity.
module tb_key_event;

   localparam int Deb  = 4;
   localparam int Long = 20;
   localparam int Rep  = 5;

   // Expected output vector: {key_level, press, release, short, long, repeat}
   localparam logic [5:0] Z    = 6'b000000;
   localparam logic [5:0] Lvl  = 6'b100000;
   localparam logic [5:0] Prs  = 6'b110000;
   localparam logic [5:0] RelS = 6'b001100;

   logic clk = 1'b0;
   logic rst_n;
   logic key_al, key_ah;
   logic lvl_al, prs_al, rel_al, sht_al, lng_al, rpt_al;
   logic lvl_ah, prs_ah, rel_ah, sht_ah, lng_ah, rpt_ah;
   logic [5:0] out_al, out_ah;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic       pressed;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   assign out_al = {lvl_al, prs_al, rel_al, sht_al, lng_al, rpt_al};
   assign out_ah = {lvl_ah, prs_ah, rel_ah, sht_ah, lng_ah, rpt_ah};

   key_event #(
      .ACTIVE_LOW  (1'b1),
      .DEBOUNCE_CYC(Deb),
      .LONG_CYC    (Long),
      .REPEAT_CYC  (Rep),
      .CW          (8)
   ) dut_al (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_al),
      .key_level    (lvl_al),
      .press_pulse  (prs_al),
      .release_pulse(rel_al),
      .short_pulse  (sht_al),
      .long_pulse   (lng_al),
      .repeat_pulse (rpt_al)
   );

   key_event #(
      .ACTIVE_LOW  (1'b0),
      .DEBOUNCE_CYC(Deb),
      .LONG_CYC    (Long),
      .REPEAT_CYC  (Rep),
      .CW          (8)
   ) dut_ah (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_ah),
      .key_level    (lvl_ah),
      .press_pulse  (prs_ah),
      .release_pulse(rel_ah),
      .short_pulse  (sht_ah),
      .long_pulse   (lng_ah),
      .repeat_pulse (rpt_ah)
   );

   task automatic drive(input logic pressed);
      key_al = ~pressed;
      key_ah = pressed;
   endtask

   task automatic chk(input string name, input int k, input logic [5:0] exp);
      n_chk = n_chk + 2;
      if (out_al !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s cycle %0d active-low: got %b expected %b", name, k, out_al, exp);
      end
      if (out_ah !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s cycle %0d active-high: got %b expected %b", name, k, out_ah, exp);
      end
   endtask

   task automatic add(input string name, input logic pressed, input logic [5:0] exp,
                      input int cnt);
      vec_t v;
      v.name    = name;
      v.pressed = pressed;
      v.exp     = exp;
      for (int i = 0; i < cnt; i++) tbl.push_back(v);
   endtask

   // Cycle k applies the key level before edge k and checks the outputs just after it.
   // Expected event cycles are hand-computed and passed in; key_level follows from them.
   task automatic run_case(input string name, input int n, input int rel_from,
                           input int glitch_at, input int rst_at, input int press_at,
                           input int press2_at, input int long_at, input int rep_first,
                           input int rep_n, input int rel_at, input logic short_exp);
      logic       lvl;
      logic       p, l, r, rp, pressed;
      logic [5:0] exp;
      lvl = 1'b0;
      for (int k = 1; k <= n; k++) begin
         pressed = (k < rel_from) && !(glitch_at > 0 && k >= glitch_at && k < glitch_at + 2);
         drive(pressed);
         rst_n = (k == rst_at) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         p  = (k == press_at) || (k == press2_at);
         l  = (k == long_at);
         r  = (k == rel_at);
         rp = (rep_n > 0) && (k >= rep_first) && (((k - rep_first) % Rep) == 0)
              && (((k - rep_first) / Rep) < rep_n);
         if (k == rst_at) lvl = 1'b0;
         else if (p) lvl = 1'b1;
         else if (r) lvl = 1'b0;
         exp = {lvl, p, r, r && short_exp, l, rp};
         if (k == rst_at) exp = Z;
         chk(name, k, exp);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", 0, Z);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_reset", 0, Z);

      // Clean press: pressed 12 cycles; press at 7, release+short 7 edges after letting go.
      add("clean", 1'b1, Z, 6);
      add("clean", 1'b1, Prs, 1);
      add("clean", 1'b1, Lvl, 5);
      add("clean", 1'b0, Lvl, 6);
      add("clean", 1'b0, RelS, 1);
      add("clean", 1'b0, Z, 3);
      // Bounce: 2 pressed, 1 released, 1 pressed, then released; never debounced.
      add("bounce", 1'b1, Z, 2);
      add("bounce", 1'b0, Z, 1);
      add("bounce", 1'b1, Z, 1);
      add("bounce", 1'b0, Z, 8);
      // 10-cycle press.
      add("press10", 1'b1, Z, 6);
      add("press10", 1'b1, Prs, 1);
      add("press10", 1'b1, Lvl, 3);
      add("press10", 1'b0, Lvl, 6);
      add("press10", 1'b0, RelS, 1);
      add("press10", 1'b0, Z, 3);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].pressed);
         @(posedge clk);
         #1;
         chk(tbl[i].name, i, tbl[i].exp);
      end

      // Long hold, 40 cycles after accept: long at 27, repeats 32..47, release at 54.
      run_case("long_hold", 58, 48, 0, 0, 7, 0, 27, 32, 4, 54, 1'b0);
      // Release glitch: two frozen cycles plus the return edge push long from 27 to 30.
      run_case("rel_glitch", 46, 36, 12, 0, 7, 0, 30, 35, 1, 42, 1'b0);
      // Reset in LONG_HELD at edge 30; held key re-debounces to a press at 37.
      run_case("reset_hold", 50, 40, 0, 30, 7, 37, 27, 0, 0, 46, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
